// File: rtl/button_debouncer_if.sv
// button_debouncer_if
//   Bundles the button pin and the debounced outputs between the debouncer
//   (master, producer of the clean level and event pulses) and whatever sits
//   on the pin/consumer side (slave).
//
//   button_raw        raw pin, asynchronous, may bounce
//   button_level      debounced level, 1 = pressed
//   press_pulse       one-cycle pulse when button_level rises
//   release_pulse     one-cycle pulse when button_level falls
//   long_press_pulse  one-cycle pulse, at most once per press
interface button_debouncer_if;
  logic button_raw;
  logic button_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press_pulse;

  modport master (
    input  button_raw,
    output button_level,
    output press_pulse,
    output release_pulse,
    output long_press_pulse
  );

  modport slave (
    output button_raw,
    input  button_level,
    input  press_pulse,
    input  release_pulse,
    input  long_press_pulse
  );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer
//   Turns a raw, bouncing, asynchronous push-button pin into a clean
//   synchronous level plus one-cycle press / release / long-press pulses.
//   A 2-flop synchronizer feeds a 4-state debounce FSM; a level change is
//   accepted only after DEBOUNCE_CYCLES consecutive agreeing samples.
//
//   Ports:
//     clk    system clock, all state on the rising edge
//     reset  asynchronous, active-low reset (0 = reset asserted)
//     bif    button_debouncer_if.master (button_raw in; button_level,
//            press_pulse, release_pulse, long_press_pulse out)
//
//   Build option:
//     BUTTON_LONG_PRESS_EN  when defined, adds the long-press timer. When
//                           undefined, long_press_pulse is tied to 0 and the
//                           LONG_* parameters have no effect.
//
//   state        | meaning
//   RELEASED     | stable released, level 0
//   PRESS_WAIT   | sync2 high, counting towards an accepted press
//   PRESSED      | stable pressed, level 1
//   RELEASE_WAIT | sync2 low, counting towards an accepted release
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int CNT_WIDTH         = 16,
  parameter int LONG_PRESS_CYCLES = 1000000,
  parameter int LONG_WIDTH        = 24
) (
  input  logic               clk,
  input  logic               reset,
  button_debouncer_if.master bif
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 button_level;
  logic                 press_pulse;
  logic                 release_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bif.button_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= RELEASED;
      cnt           <= '0;
      button_level  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          if (sync2) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_WIDTH'(1);
          end else begin
            cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state        <= PRESSED;
            button_level <= 1'b1;
            press_pulse  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        PRESSED: begin
          if (!sync2) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_WIDTH'(1);
          end
        end
        RELEASE_WAIT: begin
          // A bounce back high is the same press: return without a pulse.
          if (sync2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state         <= RELEASED;
            button_level  <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state        <= RELEASED;
          cnt          <= '0;
          button_level <= 1'b0;
        end
      endcase
    end
  end

  assign bif.button_level  = button_level;
  assign bif.press_pulse   = press_pulse;
  assign bif.release_pulse = release_pulse;

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [LONG_WIDTH-1:0] LONG_LAST = LONG_WIDTH'(LONG_PRESS_CYCLES - 1);

  logic [LONG_WIDTH-1:0] lcnt;
  logic                  long_fired;
  logic                  long_press_pulse;
  logic                  release_accept;

  // Same condition that moves the FSM from RELEASE_WAIT to RELEASED, so the
  // timer is already clear on the first RELEASED cycle.
  assign release_accept = (state == RELEASE_WAIT) && !sync2 && (cnt == DB_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lcnt             <= '0;
      long_fired       <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      long_press_pulse <= 1'b0;
      case (state)
        PRESSED: begin
          // Saturates at the terminal count; long_fired limits it to one pulse.
          if (lcnt == LONG_LAST) begin
            if (!long_fired) begin
              long_press_pulse <= 1'b1;
              long_fired       <= 1'b1;
            end
          end else begin
            lcnt <= lcnt + LONG_WIDTH'(1);
          end
        end
        RELEASE_WAIT: begin
          // Time spent here does not count towards a long press.
          if (release_accept) begin
            lcnt       <= '0;
            long_fired <= 1'b0;
          end
        end
        default: begin
          lcnt       <= '0;
          long_fired <= 1'b0;
        end
      endcase
    end
  end

  assign bif.long_press_pulse = long_press_pulse;
`else
  // Long-press feature compiled out: the LONG_* parameters only feed this
  // constant, which is ANDed down to 0.
  localparam logic LONG_TIE_OFF = 1'b0 & (LONG_PRESS_CYCLES > 0) & (LONG_WIDTH > 0);

  assign bif.long_press_pulse = LONG_TIE_OFF;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer
//   Directed stimulus for button_debouncer with DEBOUNCE_CYCLES=4 and
//   LONG_PRESS_CYCLES=20. Each stimulus step pushes the pulses it should
//   cause (kind + cycle) into a queue; a monitor on the falling edge pops
//   and compares whenever the DUT raises a pulse.
module tb_button_debouncer;
  localparam int DB = 4;
  localparam int LP = 20;

  logic clk = 1'b0;
  logic reset;

  button_debouncer_if bif ();

  button_debouncer #(
    .DEBOUNCE_CYCLES  (DB),
    .CNT_WIDTH        (8),
    .LONG_PRESS_CYCLES(LP),
    .LONG_WIDTH       (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bif  (bif)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; read on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ev(input ev_kind_t k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Handle one observed pulse of kind k.
  task automatic take(input ev_kind_t k, input int lvl_exp);
    if (exp_q.size() > 0 && exp_q[0].kind == k) begin
      check({k.name(), "_cycle"}, cyc, exp_q[0].cyc);
      check({k.name(), "_level"}, int'(bif.button_level), lvl_exp);
      void'(exp_q.pop_front());
    end else begin
      check({"spurious_", k.name()}, 1, 0);
    end
  endtask

  always @(negedge clk) begin
    // Expected pulses whose cycle has passed without being seen.
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check({"missed_", exp_q[0].kind.name(), "_cycle"}, cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (bif.press_pulse)      take(EV_PRESS, 1);
    if (bif.release_pulse)    take(EV_RELEASE, 0);
    if (bif.long_press_pulse) take(EV_LONG, 1);
  end

  initial begin
    int c;
    reset          = 1'b0;
    bif.button_raw = 1'b1;

    // Reset held with the button down: everything stays 0.
    step(10);
    check("rst_level",   int'(bif.button_level),     0);
    check("rst_press",   int'(bif.press_pulse),      0);
    check("rst_release", int'(bif.release_pulse),    0);
    check("rst_long",    int'(bif.long_press_pulse), 0);

    // Release reset with button held: first sample at c+1, level at c+1+DB+1.
    c = cyc;
    reset = 1'b1;
    expect_ev(EV_PRESS, c + DB + 2);
    step(4);
    check("pre_press_level", int'(bif.button_level), 0);
    step(8);
    c = cyc;
    bif.button_raw = 1'b0;
    expect_ev(EV_RELEASE, c + DB + 2);
    step(12);

    // Bounce 1,0,1,0,1 then hold high.
    bif.button_raw = 1'b1; step(1);
    bif.button_raw = 1'b0; step(1);
    bif.button_raw = 1'b1; step(1);
    bif.button_raw = 1'b0; step(1);
    check("bounce_level", int'(bif.button_level), 0);
    c = cyc;
    bif.button_raw = 1'b1;
    expect_ev(EV_PRESS, c + DB + 2);
    step(12);
    c = cyc;
    bif.button_raw = 1'b0;
    expect_ev(EV_RELEASE, c + DB + 2);
    step(12);

    // Three-cycle glitch: never accepted.
    bif.button_raw = 1'b1; step(3);
    bif.button_raw = 1'b0; step(15);
    check("glitch_level", int'(bif.button_level), 0);

    // Press, 2-cycle low bounce, hold. Two RELEASE_WAIT cycles delay the
    // long press from P+20 to P+22 (P = c+6).
    c = cyc;
    bif.button_raw = 1'b1;
    expect_ev(EV_PRESS, c + DB + 2);
`ifdef BUTTON_LONG_PRESS_EN
    expect_ev(EV_LONG, c + DB + 2 + LP + 2);
`endif
    step(10);
    bif.button_raw = 1'b0; step(2);
    bif.button_raw = 1'b1; step(8);
    check("rel_bounce_level", int'(bif.button_level), 1);
    step(20);
    c = cyc;
    bif.button_raw = 1'b0;
    expect_ev(EV_RELEASE, c + DB + 2);
    step(12);

    // Plain 40-cycle hold: long press exactly LP cycles after entering PRESSED.
    c = cyc;
    bif.button_raw = 1'b1;
    expect_ev(EV_PRESS, c + DB + 2);
`ifdef BUTTON_LONG_PRESS_EN
    expect_ev(EV_LONG, c + DB + 2 + LP);
`endif
    step(40);
    c = cyc;
    bif.button_raw = 1'b0;
    expect_ev(EV_RELEASE, c + DB + 2);
    step(12);

    // Async reset mid-press: level drops at once, no release pulse.
    c = cyc;
    bif.button_raw = 1'b1;
    expect_ev(EV_PRESS, c + DB + 2);
    step(10);
    check("pre_async_level", int'(bif.button_level), 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_level", int'(bif.button_level), 0);
    step(3);
    check("async_hold_level", int'(bif.button_level), 0);
    // Button still held: re-debounced from scratch after reset release.
    c = cyc;
    reset = 1'b1;
    expect_ev(EV_PRESS, c + DB + 2);
    step(12);
    c = cyc;
    bif.button_raw = 1'b0;
    expect_ev(EV_RELEASE, c + DB + 2);
    step(12);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
